dev_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the peripheral device bus in front of the address-decode bridge (timer TC0/TC1 window 0x7F00-0x7F1B).
- Shares the bus between M0 (CPU data port) and M1 (DMA/debug master) with round-robin priority and a bounded lock for back-to-back transactions.
- Runs each access as a fixed two-cycle sequence: ADDR, then DATA.
- Drives address, write data and write enable toward the bridge, and returns read data to the winning master with a one-cycle ack.

---
 rtl/dev_bus_arbiter_pkg.sv | 21 ++
 rtl/dev_bus_arbiter_rr_pick2.sv | 35 +++
 rtl/dev_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dev_bus_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types and constants for the two-master device bus arbiter.
// State encoding, master indices and the timer window base addresses.
package dev_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

    function automatic logic other(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr_pick2.sv
// Combinational two-way grant picker: lock break, lock hold, round robin.
// Ports: req[1:0], last_gnt, locked, owner, lock_break -> gnt, valid.
module dev_bus_arbiter_rr_pick2
    import dev_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       locked,
    input  logic       owner,
    input  logic       lock_break,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        gnt   = M0;
        valid = 1'b0;
        if (lock_break) begin
            // starvation bound reached: hand the bus to the waiting master
            gnt   = other(owner);
            valid = req[other(owner)];
        end else if (locked) begin
            gnt   = owner;
            valid = req[owner];
        end else begin
            valid = |req;
            if (req == 2'b11) begin
                gnt = other(last_gnt);
            end else begin
                gnt = req[1] ? M1 : M0;
            end
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter with bounded lock and ADDR/DATA sequencing.
// Ports: clk, reset, m0_*/m1_* master buses, dev_* bridge side, busy, owner.
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dev_addr,
    output logic [DW-1:0] dev_wdata,
    output logic          dev_we,
    input  logic [DW-1:0] dev_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_gnt_q, last_gnt_d;
    logic            locked_q, locked_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]   m1_rdata_q, m1_rdata_d;

    logic [1:0] req;
    logic [1:0] lock_in;
    logic       own_lock;
    logic       oth_req;
    logic       eff_locked;
    logic       lock_break;
    logic       pick_gnt;
    logic       pick_vld;

    assign req        = {m1_req, m0_req};
    assign lock_in    = {m1_lock, m0_lock};
    assign own_lock   = lock_in[owner_q];
    assign oth_req    = req[other(owner_q)];
    // a low lock input from the owner releases the lock this same cycle
    assign eff_locked = locked_q & own_lock;
    assign lock_break = eff_locked & oth_req & (lock_cnt_q == CNT_MAX);

    dev_bus_arbiter_rr_pick2 u_pick (
        .req        (req),
        .last_gnt   (last_gnt_q),
        .locked     (eff_locked),
        .owner      (owner_q),
        .lock_break (lock_break),
        .gnt        (pick_gnt),
        .valid      (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (locked_q && (!own_lock || lock_break)) begin
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end
                if (pick_vld) begin
                    owner_d = pick_gnt;
                    addr_d  = (pick_gnt == M1) ? m1_addr : m0_addr;
                    we_d    = (pick_gnt == M1) ? m1_we : m0_we;
                    wdata_d = (pick_gnt == M1) ? m1_wdata : m0_wdata;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (owner_q == M1) begin
                    m1_rdata_d = dev_rdata;
                end else begin
                    m0_rdata_d = dev_rdata;
                end
                state_d = ST_DATA;
            end
            ST_DATA: begin
                last_gnt_d = owner_q;
                if (own_lock) begin
                    locked_d = 1'b1;
                    // only grants made under an existing lock count
                    // toward the starvation bound
                    if (locked_q && oth_req && lock_cnt_q != CNT_MAX) begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                end else begin
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= M0;
            last_gnt_q <= M1;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_we    = (state_q == ST_ADDR) && we_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign m0_ack    = (state_q == ST_DATA) && (owner_q == M0);
    assign m1_ack    = (state_q == ST_DATA) && (owner_q == M1);
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter with an ack scoreboard.
// Mock bridge returns address-derived read data.
module tb_dev_bus_arbiter;
    import dev_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m0_we, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_lock, m1_we, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic        dev_we, busy, owner;

    typedef struct {
        logic        idx;
        logic        chk;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_run;
    int   n_fail;

    always #5 clk = ~clk;

    function automatic logic [31:0] bridge_rd(input logic [31:0] a);
        if (a == 32'h0000_7F04) return 32'h0000_1234;
        return {a[15:0], 16'hC0DE};
    endfunction

    assign dev_rdata = bridge_rd(dev_addr);

    dev_bus_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_rdata (dev_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #2;
        n_run++;
        if ({m0_ack, m1_ack, dev_we, busy, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {m0_ack, m1_ack, dev_we, busy, owner});
        end
        n_run++;
        if (dev_addr !== 32'h0 || dev_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dev got %h/%h want 0/0", dev_addr, dev_wdata);
        end
        n_run++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h/%h want 0/0", m0_rdata, m1_rdata);
        end
        step();
        reset = 1'b0;
        step();
        step();
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_read;
        exp_t e;
        int   cyc;
        bit   done;
        bit   we_seen;
        do_reset();
        m0_addr = 32'h0000_7F04;
        m0_we   = 1'b0;
        m0_req  = 1'b1;
        sb.push_back('{idx: M0, chk: 1'b1, rd: 32'h0000_1234});
        cyc = 0; done = 0; we_seen = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
            we_seen |= dev_we;
            if (m1_ack) begin
                n_run++; n_fail++;
                $display("FAIL rd_m1_ack got 1 want 0");
            end
            if (busy && !m0_ack) begin
                n_run++;
                if (dev_addr !== 32'h0000_7F04) begin
                    n_fail++;
                    $display("FAIL rd_addr_a got %h want 00007f04", dev_addr);
                end
            end
            if (m0_ack) begin
                done = 1;
                m0_req = 1'b0;
                e = sb.pop_front();
                n_run++;
                if (dev_addr !== 32'h0000_7F04) begin
                    n_fail++;
                    $display("FAIL rd_addr_d got %h want 00007f04", dev_addr);
                end
                n_run++;
                if (m0_rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL rd_data got %h want %h", m0_rdata, e.rd);
                end
                n_run++;
                if (cyc != 2) begin
                    n_fail++;
                    $display("FAIL rd_latency got %0d want 2", cyc);
                end
            end
        end
        n_run++;
        if (!done) begin
            n_fail++;
            $display("FAIL rd_timeout got no ack want ack");
        end
        n_run++;
        if (we_seen) begin
            n_fail++;
            $display("FAIL rd_we got 1 want 0");
        end
        step();
        n_run++;
        if (m0_ack !== 1'b0 || m0_rdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL rd_hold got ack=%b %h want ack=0 00001234",
                     m0_ack, m0_rdata);
        end
    endtask

    task automatic test_single_write;
        exp_t e;
        int   cyc;
        int   we_cnt;
        bit   done;
        m1_addr  = TC1_BASE;
        m1_wdata = 32'h9;
        m1_we    = 1'b1;
        m1_req   = 1'b1;
        sb.push_back('{idx: M1, chk: 1'b0, rd: 32'h0});
        cyc = 0; we_cnt = 0; done = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
            if (m0_ack) begin
                n_run++; n_fail++;
                $display("FAIL wr_m0_ack got 1 want 0");
            end
            if (dev_we) begin
                we_cnt++;
                n_run++;
                if (dev_wdata !== 32'h9 || dev_addr !== TC1_BASE) begin
                    n_fail++;
                    $display("FAIL wr_bus got %h@%h want 9@%h",
                             dev_wdata, dev_addr, TC1_BASE);
                end
            end
            if (m1_ack) begin
                done = 1;
                m1_req = 1'b0;
                e = sb.pop_front();
                n_run++;
                if (e.idx !== M1 || cyc != 2) begin
                    n_fail++;
                    $display("FAIL wr_ack got m%0d@%0d want m1@2", e.idx, cyc);
                end
            end
        end
        step();
        step();
        n_run++;
        if (we_cnt != 1 || !done) begin
            n_fail++;
            $display("FAIL wr_we_cycles got %0d want 1", we_cnt);
        end
        m1_we = 1'b0;
    endtask

    task automatic test_contention;
        exp_t e;
        int   cyc, last, left0, left1;
        logic got;
        do_reset();
        m0_addr = 32'h0000_7F08;
        m1_addr = 32'h0000_7F14;
        for (int i = 0; i < 8; i++) begin
            logic w;
            w = (i % 2 == 1) ? M1 : M0;
            sb.push_back('{idx: w, chk: 1'b1,
                           rd: bridge_rd(w ? m1_addr : m0_addr)});
        end
        left0 = 4; left1 = 4;
        m0_req = 1'b1; m1_req = 1'b1;
        cyc = 0; last = -1;
        while ((left0 + left1) > 0 && cyc < 200) begin
            step();
            cyc++;
            if (m0_ack || m1_ack) begin
                got = m1_ack;
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL cont_extra got ack m%0d want none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.idx || (m0_ack && m1_ack)) begin
                        n_fail++;
                        $display("FAIL cont_order got m%0d want m%0d", got, e.idx);
                    end
                    n_run++;
                    if ((got ? m1_rdata : m0_rdata) !== e.rd) begin
                        n_fail++;
                        $display("FAIL cont_rdata got %h want %h",
                                 got ? m1_rdata : m0_rdata, e.rd);
                    end
                end
                n_run++;
                if (cyc - last != ((last < 0) ? cyc - 2 + 2 - last - 1 + 1 : 3)
                    && last >= 0) begin
                    n_fail++;
                    $display("FAIL cont_gap got %0d want 3", cyc - last);
                end
                last = cyc;
                if (got) begin left1--; m1_req = (left1 > 0); end
                else     begin left0--; m0_req = (left0 > 0); end
            end
        end
        n_run++;
        if (cyc >= 200 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL cont_done got left=%0d want 0", sb.size());
            sb.delete();
        end
        clear_inputs();
    endtask

    task automatic test_lock_bound;
        exp_t        e;
        int          cyc, last, left0, left1, k;
        logic        got;
        logic [10:0] seq;
        do_reset();
        seq = 11'b010_1010_0000;
        m0_addr = TC0_BASE;
        m1_addr = TC1_BASE;
        for (int i = 0; i < 11; i++) begin
            sb.push_back('{idx: seq[i], chk: 1'b1,
                           rd: bridge_rd(seq[i] ? TC1_BASE : TC0_BASE)});
        end
        left0 = 8; left1 = 3;
        m0_lock = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        cyc = 0; last = -1; k = 0;
        while ((left0 + left1) > 0 && cyc < 300) begin
            step();
            cyc++;
            if (m0_ack || m1_ack) begin
                got = m1_ack;
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL lock_extra got ack m%0d want none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.idx) begin
                        n_fail++;
                        $display("FAIL lock_order[%0d] got m%0d want m%0d",
                                 k, got, e.idx);
                    end
                    n_run++;
                    if ((got ? m1_rdata : m0_rdata) !== e.rd) begin
                        n_fail++;
                        $display("FAIL lock_rdata got %h want %h",
                                 got ? m1_rdata : m0_rdata, e.rd);
                    end
                end
                if (last >= 0) begin
                    n_run++;
                    if (cyc - last != 3) begin
                        n_fail++;
                        $display("FAIL lock_gap got %0d want 3", cyc - last);
                    end
                end
                last = cyc;
                k++;
                if (got) begin
                    left1--;
                    m1_req  = (left1 > 0);
                    m0_lock = 1'b0;
                end else begin
                    left0--;
                    m0_req = (left0 > 0);
                end
            end
        end
        n_run++;
        if (cyc >= 300 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL lock_done got left=%0d want 0", sb.size());
            sb.delete();
        end
        clear_inputs();
    endtask

    task automatic test_lock_release;
        exp_t e;
        int   cyc, n0, left0, left1;
        bit   drop;
        logic got;
        logic [4:0] seq;
        do_reset();
        seq = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{idx: seq[i], chk: 1'b0, rd: 32'h0});
        end
        m0_addr = 32'h0000_7F0C;
        m1_addr = 32'h0000_7F18;
        m0_lock = 1'b1;
        m0_req  = 1'b1;
        left0 = 4; left1 = 0; n0 = 0; drop = 0; cyc = 0;
        while ((left0 + left1) > 0 && cyc < 200) begin
            step();
            cyc++;
            if (drop) begin
                m0_lock = 1'b0;
                drop = 0;
            end
            if (m0_ack || m1_ack) begin
                got = m1_ack;
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rel_extra got ack m%0d want none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.idx) begin
                        n_fail++;
                        $display("FAIL rel_order got m%0d want m%0d", got, e.idx);
                    end
                end
                if (got) begin
                    left1--;
                    m1_req = (left1 > 0);
                end else begin
                    left0--;
                    n0++;
                    m0_req = (left0 > 0);
                    if (n0 == 2) drop = 1;
                    if (n0 == 3) begin
                        m1_req = 1'b1;
                        left1  = 1;
                    end
                end
            end
        end
        n_run++;
        if (cyc >= 200 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rel_done got left=%0d want 0", sb.size());
            sb.delete();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        int   cyc, acks;
        bit   done;
        do_reset();
        m0_addr  = TC0_BASE;
        m0_wdata = 32'hA5;
        m0_we    = 1'b1;
        m0_req   = 1'b1;
        step();
        n_run++;
        if (dev_we !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_addr got we=%b busy=%b want 1/1", dev_we, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_run++;
        if ({dev_we, busy, m0_ack, m1_ack} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_abort got %b want 0000",
                     {dev_we, busy, m0_ack, m1_ack});
        end
        m1_addr = 32'h0000_7F14;
        m1_req  = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            acks += int'(m0_ack) + int'(m1_ack);
        end
        reset = 1'b0;
        n_run++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL mid_no_ack got %0d want 0", acks);
        end
        cyc = 0; done = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
            if (m0_ack || m1_ack) begin
                done = 1;
                n_run++;
                if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || cyc != 2) begin
                    n_fail++;
                    $display("FAIL mid_tie got m0=%b m1=%b@%0d want m0@2",
                             m0_ack, m1_ack, cyc);
                end
            end
        end
        n_run++;
        if (!done) begin
            n_fail++;
            $display("FAIL mid_timeout got no ack want ack");
        end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lock_bound();
        test_lock_release();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
